reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement queue between dispatcher, execution units and the register file.
//  Dispatcher allocates one entry per issued instruction and receives its rename tag (ROB id).
//  The CDB writes results back; the head entry retires in order, driving commit_flag, rd, Q and V to the register file.
//  A mispredicted branch at the head drives rollback_flag and a redirect PC, then flushes the buffer.
// PARAMETERS
//  ROB_SIZE  16  entry count; ROB id = slot index + 1, so id 0 (ZERO_ROB) means "no producer"
//  ID_W      5   ROB id width; must satisfy 2^ID_W > ROB_SIZE
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous, active-high reset
//  alloc_en       in   1     dispatcher allocates an entry this cycle
//  alloc_rd       in   5     destination register (0 = no writeback)
//  alloc_is_br    in   1     entry is a branch/jump
//  alloc_pred     in   1     predicted taken
//  alloc_id       out  ID_W  id the next allocation receives (tail+1), combinational
//  full           out  1     count == ROB_SIZE, combinational
//  cdb_en         in   1     result broadcast valid
//  cdb_id         in   ID_W  producing entry id
//  cdb_val        in   32    result value
//  cdb_taken      in   1     actual branch outcome
//  cdb_target     in   32    correct next PC if mispredicted
//  q_id1/q_id2    in   ID_W  operand tags queried by dispatcher
//  q_rdy1/q_rdy2  out  1     tag result available (combinational)
//  q_val1/q_val2  out  32    that result
//  commit_flag    out  1     registered one-cycle retire pulse to register file
//  rollback_flag  out  1     registered one-cycle flush pulse
//  commit_rd      out  5     retired rd
//  commit_Q       out  ID_W  retired id
//  commit_V       out  32    retired value
//  jump_pc        out  32    redirect PC, valid with rollback_flag
// BEHAVIOUR
//  - Reset: head=tail=count=0, all valid/ready bits 0; all outputs 0 the cycle after rst.
//  - Ring buffer; head and tail wrap ROB_SIZE-1 -> 0; count tracks occupancy.
//  - Alloc: if alloc_en && !full, at the edge write slot[tail] (valid=1, ready=0), tail++.
//    alloc_en while full is ignored; alloc_id is unchanged.
//  - Writeback: cdb_en with an id of a valid slot sets ready, val, taken and target at the edge.
//    Writeback to id 0 or to an invalid slot is ignored.
//  - Retire: if slot[head] is valid and ready at the edge, then at that edge:
//    - Register commit_flag=1, commit_rd, commit_Q=head+1 and commit_V.
//    - head++, count-- (count unchanged if an allocation happens at the same edge).
//  - At most one retire per cycle. commit_flag stays 0 in every cycle with no retire.
//    A result written in cycle N retires no earlier than edge N+1 (ready is registered).
//  - Mispredict: a retiring branch with taken != pred also registers rollback_flag=1 and jump_pc=target.
//    - At the same edge, clear all valid bits and set head=tail=count=0.
//    - An alloc_en at that edge is dropped. A jump writing rd gives commit_flag=1 and rollback_flag=1 together.
//  - Query (per port): id 0 -> rdy=1, val=0; cdb_en && cdb_id==q_id -> rdy=1, val=cdb_val (bypass).
//    Otherwise rdy = slot valid && ready, val = slot value.
//  - Reset mid-operation discards all entries; no commit pulse is emitted for them.
// STRUCTURE
//  - Shared defines package: ROB_ID_TYPE, ZERO_ROB, REG_POS_TYPE, ZERO_REG, DATA_TYPE, ADDR_TYPE, TRUE/FALSE, ROB_SIZE.
//  - One natural sub-module, rob_query_port, instantiated twice: tag lookup plus CDB bypass.
//  - Storage arrays and the pointers stay inline.
// TESTING
//  - Reset, then alloc rd=5 -> alloc_id=1; cdb id1 val=0x2A.
//    -> commit_flag at the next edge with rd=5, Q=1, V=0x2A; count returns to 0.
//  - Out-of-order completion: alloc ids 1,2,3; cdb order 3,2,1.
//    -> commits in order 1,2,3 on consecutive cycles, each a one-cycle pulse.
//  - Fill 16 entries -> full=1; a 17th alloc_en is ignored and alloc_id stays 1 (wrapped).
//    Retire one -> full=0; the next alloc gets id 1.
//  - Branch id2 pred=0, cdb taken=1 target=0x100, ids 3,4 pending.
//    -> rollback_flag=1, jump_pc=0x100; then count=0 and alloc_id=1; cdb to id 3 is ignored.
//  - Query q_id1=4 in the cycle cdb_en id4 val=7 -> q_rdy1=1, q_val1=7.
//    Query q_id1=0 -> rdy=1, val=0.
//  - Alloc and retire at the same edge keep count constant; rst asserted with 5 entries pending.
//    -> no commit pulses afterwards and alloc_id=1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: id/register/data types and the sentinel values
// used to mean "no producer" and "no destination register".
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;
    localparam int ID_W     = 5;

    typedef logic [ID_W-1:0] ROB_ID_TYPE;
    typedef logic [4:0]      REG_POS_TYPE;
    typedef logic [31:0]     DATA_TYPE;
    typedef logic [31:0]     ADDR_TYPE;

    localparam ROB_ID_TYPE  ZERO_ROB = '0;
    localparam REG_POS_TYPE ZERO_REG = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rob_query_port.sv
// Operand tag lookup for the dispatcher: resolves a ROB id to a value, either from the
// result broadcast on the CDB this cycle or from a completed entry already in the buffer.
module rob_query_port #(
    parameter int ROB_SIZE = 16,
    parameter int ID_W     = 5
) (
    input  logic [ID_W-1:0]            q_id,
    input  logic                       cdb_en,
    input  logic [ID_W-1:0]            cdb_id,
    input  logic [31:0]                cdb_val,
    input  logic [ROB_SIZE-1:0]        slot_valid,
    input  logic [ROB_SIZE-1:0]        slot_ready,
    input  logic [ROB_SIZE-1:0][31:0]  slot_val,
    output logic                       rdy,
    output logic [31:0]                val
);
    import reorder_buffer_pkg::*;

    localparam int PTR_W = $clog2(ROB_SIZE);

    logic [PTR_W-1:0] idx;
    logic             in_range;

    assign idx      = PTR_W'(q_id - 1'b1);
    assign in_range = (q_id != ZERO_ROB) && (q_id <= ID_W'(ROB_SIZE));

    // Tag 0 means the operand comes straight from the register file, so it is always ready.
    always_comb begin
        rdy = FALSE;
        val = '0;
        if (q_id == ZERO_ROB) begin
            rdy = TRUE;
        end else if (cdb_en && (cdb_id == q_id)) begin
            rdy = TRUE;
            val = cdb_val;
        end else if (in_range) begin
            rdy = slot_valid[idx] && slot_ready[idx];
            val = slot_val[idx];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags, collects CDB results out of order,
// retires the head entry one per cycle and flushes everything on a mispredicted branch.
module reorder_buffer #(
    parameter int ROB_SIZE = reorder_buffer_pkg::ROB_SIZE,
    parameter int ID_W     = reorder_buffer_pkg::ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_br,
    input  logic             alloc_pred,
    output logic [ID_W-1:0]  alloc_id,
    output logic             full,
    input  logic             cdb_en,
    input  logic [ID_W-1:0]  cdb_id,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_taken,
    input  logic [31:0]      cdb_target,
    input  logic [ID_W-1:0]  q_id1,
    input  logic [ID_W-1:0]  q_id2,
    output logic             q_rdy1,
    output logic             q_rdy2,
    output logic [31:0]      q_val1,
    output logic [31:0]      q_val2,
    output logic             commit_flag,
    output logic             rollback_flag,
    output logic [4:0]       commit_rd,
    output logic [ID_W-1:0]  commit_Q,
    output logic [31:0]      commit_V,
    output logic [31:0]      jump_pc
);
    import reorder_buffer_pkg::*;

    localparam int PTR_W = $clog2(ROB_SIZE);
    localparam int CNT_W = $clog2(ROB_SIZE + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(ROB_SIZE - 1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [ROB_SIZE-1:0]       valid;
    logic [ROB_SIZE-1:0]       ready;
    logic [ROB_SIZE-1:0]       is_br;
    logic [ROB_SIZE-1:0]       pred;
    logic [ROB_SIZE-1:0]       taken;
    logic [ROB_SIZE-1:0][31:0] val;
    logic [ROB_SIZE-1:0][31:0] target;
    REG_POS_TYPE               rd_mem [ROB_SIZE];

    logic             do_alloc;
    logic             head_done;
    logic             mispredict;
    logic             cdb_hit;
    logic [PTR_W-1:0] cdb_idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

    assign full       = (count == CNT_W'(ROB_SIZE));
    assign alloc_id   = ID_W'(tail) + 1'b1;
    assign do_alloc   = alloc_en && !full;
    assign head_done  = valid[head] && ready[head];
    assign mispredict = head_done && is_br[head] && (taken[head] != pred[head]);
    assign cdb_idx    = PTR_W'(cdb_id - 1'b1);
    assign cdb_hit    = cdb_en && (cdb_id != ZERO_ROB) && (cdb_id <= ID_W'(ROB_SIZE)) && valid[cdb_idx];

    // A mispredict wins over everything else at the edge: the whole window is squashed,
    // including any allocation the dispatcher attempted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            ready <= '0;
        end else if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (cdb_hit) begin
                ready[cdb_idx] <= TRUE;
            end
            if (do_alloc) begin
                valid[tail] <= TRUE;
                ready[tail] <= FALSE;
                tail        <= next_ptr(tail);
            end
            if (head_done) begin
                valid[head] <= FALSE;
                head        <= next_ptr(head);
            end
            case ({do_alloc, head_done})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset; the valid bits decide whether any of it is looked at.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            rd_mem[tail] <= alloc_rd;
            is_br[tail]  <= alloc_is_br;
            pred[tail]   <= alloc_pred;
        end
        if (cdb_hit) begin
            val[cdb_idx]    <= cdb_val;
            taken[cdb_idx]  <= cdb_taken;
            target[cdb_idx] <= cdb_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_flag   <= FALSE;
            rollback_flag <= FALSE;
            commit_rd     <= ZERO_REG;
            commit_Q      <= '0;
            commit_V      <= '0;
            jump_pc       <= '0;
        end else begin
            commit_flag   <= head_done;
            rollback_flag <= mispredict;
            if (head_done) begin
                commit_rd <= rd_mem[head];
                commit_Q  <= ID_W'(head) + 1'b1;
                commit_V  <= val[head];
            end
            if (mispredict) begin
                jump_pc <= target[head];
            end
        end
    end

    rob_query_port #(.ROB_SIZE(ROB_SIZE), .ID_W(ID_W)) u_query1 (
        .q_id       (q_id1),
        .cdb_en     (cdb_en),
        .cdb_id     (cdb_id),
        .cdb_val    (cdb_val),
        .slot_valid (valid),
        .slot_ready (ready),
        .slot_val   (val),
        .rdy        (q_rdy1),
        .val        (q_val1)
    );

    rob_query_port #(.ROB_SIZE(ROB_SIZE), .ID_W(ID_W)) u_query2 (
        .q_id       (q_id2),
        .cdb_en     (cdb_en),
        .cdb_id     (cdb_id),
        .cdb_val    (cdb_val),
        .slot_valid (valid),
        .slot_ready (ready),
        .slot_val   (val),
        .rdy        (q_rdy2),
        .val        (q_val2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked every cycle
// against a queue-of-instructions model of in-order retirement.
module tb_reorder_buffer;

    localparam int ROB_SIZE = 16;
    localparam int ID_W     = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_en, alloc_is_br, alloc_pred;
    logic [4:0]      alloc_rd;
    logic [ID_W-1:0] alloc_id;
    logic            full;
    logic            cdb_en, cdb_taken;
    logic [ID_W-1:0] cdb_id;
    logic [31:0]     cdb_val, cdb_target;
    logic [ID_W-1:0] q_id1, q_id2;
    logic            q_rdy1, q_rdy2;
    logic [31:0]     q_val1, q_val2;
    logic            commit_flag, rollback_flag;
    logic [4:0]      commit_rd;
    logic [ID_W-1:0] commit_Q;
    logic [31:0]     commit_V, jump_pc;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_is_br(alloc_is_br), .alloc_pred(alloc_pred),
        .alloc_id(alloc_id), .full(full),
        .cdb_en(cdb_en), .cdb_id(cdb_id), .cdb_val(cdb_val), .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .q_id1(q_id1), .q_id2(q_id2), .q_rdy1(q_rdy1), .q_rdy2(q_rdy2), .q_val1(q_val1), .q_val2(q_val2),
        .commit_flag(commit_flag), .rollback_flag(rollback_flag), .commit_rd(commit_rd),
        .commit_Q(commit_Q), .commit_V(commit_V), .jump_pc(jump_pc)
    );

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic        is_br;
        logic        pred;
        logic        done;
        logic        taken;
        logic [31:0] val;
        logic [31:0] target;
    } entry_t;

    entry_t      model_q[$];
    int          next_id = 1;
    int          test_count = 0;
    int          fail_count = 0;
    logic        exp_commit, exp_rollback;
    logic [31:0] exp_rd, exp_q, exp_v, exp_pc;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic a_en, input logic [4:0] a_rd, input logic a_br, input logic a_pred,
                                 input logic c_en, input logic [4:0] c_id, input logic [31:0] c_val,
                                 input logic c_taken, input logic [31:0] c_target,
                                 input logic [4:0] id1, input logic [4:0] id2);
        alloc_en    = a_en;
        alloc_rd    = a_rd;
        alloc_is_br = a_br;
        alloc_pred  = a_pred;
        cdb_en      = c_en;
        cdb_id      = c_id;
        cdb_val     = c_val;
        cdb_taken   = c_taken;
        cdb_target  = c_target;
        q_id1       = id1;
        q_id2       = id2;
    endtask

    function automatic void model_reset();
        model_q.delete();
        next_id      = 1;
        exp_commit   = 1'b0;
        exp_rollback = 1'b0;
        exp_rd       = '0;
        exp_q        = '0;
        exp_v        = '0;
        exp_pc       = '0;
    endfunction

    function automatic void model_query(input logic [4:0] id, output logic rdy, output logic [31:0] v);
        rdy = 1'b0;
        v   = '0;
        if (id == 5'd0) begin
            rdy = 1'b1;
        end else if (cdb_en && cdb_id == id) begin
            rdy = 1'b1;
            v   = cdb_val;
        end else begin
            foreach (model_q[i]) begin
                if (model_q[i].id == int'(id) && model_q[i].done) begin
                    rdy = 1'b1;
                    v   = model_q[i].val;
                end
            end
        end
    endfunction

    // One clock edge of the reference: oldest finished instruction leaves, results land, new one joins.
    function automatic void model_edge();
        logic   retire, mis, can_alloc;
        entry_t e;
        if (rst) begin
            model_reset();
            return;
        end
        retire    = (model_q.size() > 0) && model_q[0].done;
        mis       = retire && model_q[0].is_br && (model_q[0].taken != model_q[0].pred);
        can_alloc = alloc_en && (model_q.size() < ROB_SIZE) && !mis;
        exp_commit   = retire;
        exp_rollback = mis;
        if (retire) begin
            exp_rd = 32'(model_q[0].rd);
            exp_q  = 32'(model_q[0].id);
            exp_v  = model_q[0].val;
        end
        if (mis) exp_pc = model_q[0].target;
        if (cdb_en) begin
            foreach (model_q[i]) begin
                if (model_q[i].id == int'(cdb_id)) begin
                    model_q[i].done   = 1'b1;
                    model_q[i].val    = cdb_val;
                    model_q[i].taken  = cdb_taken;
                    model_q[i].target = cdb_target;
                end
            end
        end
        if (mis) begin
            model_q.delete();
            next_id = 1;
        end else begin
            if (retire) void'(model_q.pop_front());
            if (can_alloc) begin
                e.id     = next_id;
                e.rd     = alloc_rd;
                e.is_br  = alloc_is_br;
                e.pred   = alloc_pred;
                e.done   = 1'b0;
                e.taken  = 1'b0;
                e.val    = '0;
                e.target = '0;
                model_q.push_back(e);
                next_id = (next_id == ROB_SIZE) ? 1 : next_id + 1;
            end
        end
    endfunction

    task automatic clock_cycle();
        logic        r1, r2;
        logic [31:0] v1, v2;
        @(negedge clk);
        checkOutput("alloc_id", 32'(alloc_id), 32'(next_id));
        checkOutput("full", 32'(full), 32'(model_q.size() == ROB_SIZE));
        model_query(q_id1, r1, v1);
        model_query(q_id2, r2, v2);
        checkOutput("q_rdy1", 32'(q_rdy1), 32'(r1));
        checkOutput("q_rdy2", 32'(q_rdy2), 32'(r2));
        if (r1) checkOutput("q_val1", q_val1, v1);
        if (r2) checkOutput("q_val2", q_val2, v2);
        model_edge();
        @(posedge clk);
        #1;
        checkOutput("commit_flag", 32'(commit_flag), 32'(exp_commit));
        checkOutput("rollback_flag", 32'(rollback_flag), 32'(exp_rollback));
        checkOutput("commit_rd", 32'(commit_rd), exp_rd);
        checkOutput("commit_Q", 32'(commit_Q), exp_q);
        checkOutput("commit_V", commit_V, exp_v);
        checkOutput("jump_pc", jump_pc, exp_pc);
    endtask

    task automatic do_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        clock_cycle();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic br, input logic pr);
        applyStimulus(1, rd, br, pr, 0, 0, 0, 0, 0, 0, 0);
        clock_cycle();
    endtask

    task automatic do_cdb(input logic [4:0] id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        applyStimulus(0, 0, 0, 0, 1, id, v, tk, tg, 0, 0);
        clock_cycle();
    endtask

    task automatic do_idle(input logic [4:0] id1, input logic [4:0] id2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, id1, id2);
        clock_cycle();
    endtask

    initial begin
        logic [4:0] c_id;
        logic       c_en;
        int         pick;

        do_reset();
        checkOutput("reset_commit_flag", 32'(commit_flag), 32'd0);
        checkOutput("reset_commit_V", commit_V, 32'd0);
        checkOutput("reset_alloc_id", 32'(alloc_id), 32'd1);

        // Single instruction round trip.
        do_alloc(5'd5, 0, 0);
        do_cdb(5'd1, 32'h2A, 0, 0);
        do_idle(0, 0);
        checkOutput("t1_commit_flag", 32'(commit_flag), 32'd1);
        checkOutput("t1_commit_rd", 32'(commit_rd), 32'd5);
        checkOutput("t1_commit_Q", 32'(commit_Q), 32'd1);
        checkOutput("t1_commit_V", commit_V, 32'h2A);
        do_idle(0, 0);
        checkOutput("t1_pulse_end", 32'(commit_flag), 32'd0);

        // Out-of-order completion retires in program order.
        do_reset();
        for (int i = 1; i <= 3; i++) do_alloc(5'(i), 0, 0);
        for (int i = 3; i >= 1; i--) do_cdb(5'(i), 32'(i * 16), 0, 0);
        for (int i = 1; i <= 3; i++) begin
            do_idle(0, 0);
            checkOutput("t2_commit_flag", 32'(commit_flag), 32'd1);
            checkOutput("t2_commit_Q", 32'(commit_Q), 32'(i));
        end
        do_idle(0, 0);
        checkOutput("t2_pulse_end", 32'(commit_flag), 32'd0);

        // Full buffer ignores allocation; one retire frees exactly one slot.
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) do_alloc(5'(i), 0, 0);
        checkOutput("t3_full", 32'(full), 32'd1);
        do_alloc(5'd9, 0, 0);
        checkOutput("t3_alloc_id_wrap", 32'(alloc_id), 32'd1);
        checkOutput("t3_still_full", 32'(full), 32'd1);
        do_cdb(5'd1, 32'h55, 0, 0);
        do_idle(0, 0);
        checkOutput("t3_not_full", 32'(full), 32'd0);
        checkOutput("t3_next_id", 32'(alloc_id), 32'd1);
        do_alloc(5'd3, 0, 0);
        checkOutput("t3_refull", 32'(full), 32'd1);

        // Mispredicted branch at the head flushes younger entries.
        do_reset();
        do_alloc(5'd1, 0, 0);
        do_alloc(5'd7, 1, 0);
        do_alloc(5'd3, 0, 0);
        do_alloc(5'd4, 0, 0);
        do_cdb(5'd1, 32'h11, 0, 0);
        do_cdb(5'd2, 32'h22, 1, 32'h100);
        do_idle(0, 0);
        checkOutput("t4_rollback", 32'(rollback_flag), 32'd1);
        checkOutput("t4_jump_pc", jump_pc, 32'h100);
        checkOutput("t4_commit_with_rb", 32'(commit_flag), 32'd1);
        checkOutput("t4_alloc_id", 32'(alloc_id), 32'd1);
        do_cdb(5'd3, 32'h33, 0, 0);
        do_idle(5'd3, 0);
        checkOutput("t4_no_commit", 32'(commit_flag), 32'd0);

        // Query bypass from the CDB and the zero tag.
        do_reset();
        for (int i = 1; i <= 4; i++) do_alloc(5'(i), 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 5'd4, 32'd7, 0, 0, 5'd4, 5'd0);
        #1;
        checkOutput("t5_bypass_rdy", 32'(q_rdy1), 32'd1);
        checkOutput("t5_bypass_val", q_val1, 32'd7);
        checkOutput("t5_zero_rdy", 32'(q_rdy2), 32'd1);
        checkOutput("t5_zero_val", q_val2, 32'd0);
        clock_cycle();
        do_idle(5'd4, 5'd3);

        // Simultaneous alloc/retire, then reset with entries pending.
        do_reset();
        do_alloc(5'd1, 0, 0);
        do_cdb(5'd1, 32'hAB, 0, 0);
        do_alloc(5'd2, 0, 0);
        checkOutput("t6_overlap_commit", 32'(commit_flag), 32'd1);
        for (int i = 0; i < 4; i++) do_alloc(5'(i + 10), 0, 0);
        checkOutput("t6_pending_id", 32'(alloc_id), 32'd7);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_idle(0, 0);
            checkOutput("t6_no_commit", 32'(commit_flag), 32'd0);
        end
        checkOutput("t6_alloc_id", 32'(alloc_id), 32'd1);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            pick = int'($urandom_range(0, 9));
            c_en = 1'b0;
            c_id = '0;
            if (pick < 5 && model_q.size() > 0) begin
                c_en = 1'b1;
                c_id = 5'(model_q[$urandom_range(0, model_q.size() - 1)].id);
            end else if (pick < 6) begin
                c_en = 1'b1;
                c_id = 5'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 9) < 6, 5'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                          c_en, c_id, $urandom, 1'($urandom), $urandom,
                          5'($urandom_range(0, 17)), ($urandom_range(0, 3) == 0) ? c_id : 5'($urandom_range(0, 17)));
            clock_cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
